// File: rtl/rca_seq_addsub.sv
// ---------------------------------------------------------------------------
// rca_seq_addsub
//   Multi-cycle ripple-carry adder/subtractor. A WIDTH-bit operation is
//   processed CHUNK bits per clock, least-significant chunk first, through a
//   single CHUNK-bit ripple slice. The carry between chunks is held in a
//   register, so NCH = WIDTH/CHUNK clocks produce one result.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     request; sampled only when the block is not busy
//   op_sub    0: s = a + b + ci, 1: s = a - b (a + ~b + 1); sampled with start
//   a, b      WIDTH-bit operands; sampled with start
//   ci        carry-in for add; ignored for subtract
//   busy      high while chunks are being processed
//   done      one-cycle pulse; s/co/ovf are final while it is high
//   s         sum/difference register
//   co        carry out of the MSB (subtract: 1 = no borrow, a >= b unsigned)
//   ovf       signed overflow (carry into MSB XOR carry out of MSB)
//   dbg_state current FSM state, for observation only
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0 (IDLE or DONE state). busy rises on that edge and stays high for
// NCH cycles; done then pulses for exactly one cycle. start while busy=1 is
// ignored, and a/b/ci/op_sub are only looked at on the accepting edge.
// ---------------------------------------------------------------------------
module rca_seq_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              carry_r;
    logic [CW-1:0]     cnt;

    logic [CHUNK-1:0]  a_sl, b_sl;
    logic [CHUNK:0]    sum_sl;
    logic              slice_cout;
    logic              msb_cin;
    logic              last;
    logic              accept;

    // Select the chunk addressed by cnt from the latched operands.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = a_r[k*CHUNK +: CHUNK];
                b_sl = b_r[k*CHUNK +: CHUNK];
            end
        end
    end

    assign sum_sl     = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_r};
    assign slice_cout = sum_sl[CHUNK];
    // The carry into the slice MSB is recovered from that bit's sum
    // (s = a ^ b ^ cin), which holds for any CHUNK including 1.
    assign msb_cin    = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum_sl[CHUNK-1];
    assign last       = (cnt == CW'(NCH - 1));
    assign accept     = start && (state != ST_RUN);

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: operand latch on accept, one chunk per RUN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            s       <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= op_sub ? ~b : b;
            carry_r <= op_sub ? 1'b1 : ci;
            cnt     <= '0;
        end else if (state == ST_RUN) begin
            for (int k = 0; k < NCH; k++) begin
                if (cnt == CW'(k)) s[k*CHUNK +: CHUNK] <= sum_sl[CHUNK-1:0];
            end
            carry_r <= slice_cout;
            if (last) begin
                co  <= slice_cout;
                ovf <= msb_cin ^ slice_cout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/rca_seq_addsub.md
Name: rca_seq_addsub

Overview:
Parametrised, multi-cycle, clocked adder/subtractor that generalises the fixed 32-bit ripple-carry adder.
- Processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
- Uses a CHUNK-bit ripple slice and a registered inter-chunk carry.
- Adds a start/busy/done handshake, subtract mode and a signed-overflow flag.
- Used wherever area matters more than latency, e.g. the multi-cycle datapath next to the clocked CLA.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 2.
CHUNK, 4, bits processed per cycle; must divide WIDTH; NCH = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
op_sub  input  1  0 = a+b+ci, 1 = a-b (a + ~b + 1); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
ci  input  1  carry-in for add; ignored when op_sub=1
busy  output  1  high while chunks are being processed
done  output  1  one-cycle pulse: s/co/ovf are final
s  output  WIDTH  sum/difference register
co  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- One clock domain (clk); reset_n is asynchronous, active-low.
- Reset state: IDLE. busy=0, done=0, s=0, co=0, ovf=0, chunk counter=0, internal carry=0, operand registers=0.
- State machine: IDLE -> RUN -> DONE.
- IDLE, start=1 at edge:
  - Latch a into A_r, and (op_sub ? ~b : b) into B_r.
  - Set carry_r = (op_sub ? 1 : ci) and cnt=0.
  - Go to RUN; busy=1 from this edge.
  - s/co/ovf keep their previous values until overwritten chunk by chunk.
- RUN, each edge:
  - Slice k=cnt computes A_r[k*CHUNK +: CHUNK] + B_r[k*CHUNK +: CHUNK] + carry_r.
  - Write the result to s[k*CHUNK +: CHUNK] and the slice carry-out to carry_r; cnt++.
  - On the edge where cnt==NCH-1: co <= slice carry-out; ovf <= carry into bit WIDTH-1 XOR slice carry-out; go to DONE; busy<=0; done<=1.
- DONE: lasts exactly one cycle, done=1, then IDLE with done<=0.
  - start=1 during DONE is accepted exactly as in IDLE: go to RUN, done<=0.
  - Back-to-back operations therefore have a throughput of one result per NCH+1 cycles.
- Latency: start accepted at edge E0; done is high between edges E_NCH and E_NCH+1. With defaults, done rises 8 edges after the start edge.
- start while busy=1 is ignored. Operands are not re-sampled; a/b/ci/op_sub may change freely during RUN.
- s/co/ovf hold their final values after done until the next accepted start.
- CHUNK==WIDTH (NCH=1): single RUN cycle; done is high one edge after the start edge.
- Counter width is clog2(NCH), minimum 1. No wrap is reachable: the state leaves RUN at NCH-1.
- reset_n asserted mid-operation aborts immediately. All outputs return to reset values with no done pulse. After release the block is in IDLE.
- All arithmetic is unsigned modulo 2^WIDTH; ovf interprets operands as two's complement.

Test Plan:
1. Defaults, add a=32'hFFFFFFFF, b=32'h1, ci=0 -> s=32'h0, co=1, ovf=0; done high for exactly one cycle, 8 edges after the start edge; busy high for 8 cycles.
2. Add a=32'h7FFFFFFF, b=32'h1, ci=0 -> s=32'h80000000, co=0, ovf=1. Add a=32'h1, b=32'h2, ci=1 -> s=32'h4, co=0, ovf=0.
3. Subtract:
   - a=5, b=7, ci=1 -> s=32'hFFFFFFFE, co=0, ovf=0 (ci ignored).
   - a=32'h80000000, b=1 -> s=32'h7FFFFFFF, co=1, ovf=1.
   - a=b=32'h12345678 -> s=0, co=1, ovf=0.
4. Handshake: pulse start with a=1, b=1; assert start again mid-RUN with a=9, b=9 -> the second start is ignored and s=2. Assert start in the DONE cycle with a=3, b=4 -> accepted; s=7 after a further 8 edges.
5. Reset mid-operation: drop reset_n asynchronously at RUN cnt=3 -> busy/done/s/co/ovf are 0 immediately and no done pulse follows. After release, a new add 10+20 -> s=30.
6. Parameter sweep (WIDTH=16/CHUNK=16, WIDTH=8/CHUNK=1, WIDTH=64/CHUNK=8): at least 1000 random a/b/ci/op_sub per configuration vs. a reference model. Check latency = NCH edges and s/co/ovf exact, including max/min signed operands.
